// File: rtl/instr_loader.sv
// Writer side of the instruction-screen image memory: takes a raster-ordered
// byte stream over valid/ready and writes one full image into the instruction RAM.
module instr_loader #(
    parameter int IMG_W     = 237,
    parameter int IMG_H     = 21,
    parameter int IMG1_BASE = 4977,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              img_sel,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        x_pos,
    output logic [4:0]        y_pos
);

    // state | meaning
    // IDLE  | waiting for start; stream not accepted
    // LOAD  | accepting beats, one RAM write per accepted beat
    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    localparam logic [7:0]        X_LAST   = 8'(IMG_W - 1);
    localparam logic [4:0]        Y_LAST   = 5'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] IMG1_ADR = ADDR_W'(IMG1_BASE);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;
    logic              last_beat;
    logic              load_go;
    logic              load_end;

    assign accept    = in_valid & in_ready;
    assign last_beat = (x_pos == X_LAST) && (y_pos == Y_LAST);
    assign load_go   = (state == IDLE) && start && !abort;
    assign load_end  = (state == LOAD) && (abort || (accept && last_beat));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort || (accept && last_beat)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is a running counter seeded with the image base, so no multiplier.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            addr_cnt <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
        end else begin
            wr_en <= accept;
            done  <= accept && last_beat && !abort;
            if (accept) begin
                wr_addr  <= addr_cnt;
                wr_data  <= in_data;
                addr_cnt <= addr_cnt + 1'b1;
                if (x_pos == X_LAST) begin
                    x_pos <= '0;
                    y_pos <= y_pos + 1'b1;
                end else begin
                    x_pos <= x_pos + 1'b1;
                end
            end
            if (load_go) begin
                addr_cnt <= img_sel ? IMG1_ADR : '0;
                x_pos    <= '0;
                y_pos    <= '0;
            end
            if (load_end) begin
                x_pos <= '0;
                y_pos <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: an index-based image model predicts
// every write, plus literal checks on addresses, counts and reset behaviour.
module tb_instr_loader;

    localparam int IMG_W = 237;
    localparam int IMG_H = 21;
    localparam int TOTAL = IMG_W * IMG_H;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       img_sel = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [13:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] x_pos;
    logic [4:0] y_pos;

    int n_assert = 0;
    int n_fail   = 0;

    instr_loader dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .start   (start),
        .img_sel (img_sel),
        .abort   (abort),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .x_pos   (x_pos),
        .y_pos   (y_pos)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a loader is just "beat index within the image"; pixel position
    // and address follow from plain division and multiplication.
    bit m_busy;
    int m_idx;
    int m_base;
    bit e_wr_en;
    bit e_done;
    int e_addr;
    int e_data;

    always @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            m_busy  = 0;
            m_idx   = 0;
            m_base  = 0;
            e_wr_en = 0;
            e_done  = 0;
            e_addr  = 0;
            e_data  = 0;
        end else begin
            bit acc;
            acc     = m_busy && in_valid;
            e_wr_en = acc;
            e_done  = 0;
            if (acc) begin
                e_addr = m_base + (m_idx / IMG_W) * IMG_W + (m_idx % IMG_W);
                e_data = int'(in_data);
                e_done = (m_idx == TOTAL - 1) && !abort;
            end
            if (m_busy) begin
                if (abort || (acc && m_idx == TOTAL - 1)) begin
                    m_busy = 0;
                    m_idx  = 0;
                end else if (acc) begin
                    m_idx++;
                end
            end else if (start && !abort) begin
                m_busy = 1;
                m_idx  = 0;
                m_base = img_sel ? TOTAL : 0;
            end
        end
    end

    int wcnt = 0;
    int dcnt = 0;
    int wlog [0:TOTAL-1];

    always @(negedge vga_clk) begin
        chk("in_ready", int'(in_ready), int'(m_busy));
        chk("busy", int'(busy), int'(m_busy));
        chk("wr_en", int'(wr_en), int'(e_wr_en));
        chk("done", int'(done), int'(e_done));
        chk("x_pos", int'(x_pos), m_idx % IMG_W);
        chk("y_pos", int'(y_pos), m_idx / IMG_W);
        if (e_wr_en) begin
            chk("wr_addr", int'(wr_addr), e_addr);
            chk("wr_data", int'(wr_data), e_data);
        end
        if (wr_en) begin
            if (wcnt < TOTAL) wlog[wcnt] = int'(wr_addr);
            wcnt++;
        end
        if (done) dcnt++;
    end

    task automatic tick();
        @(posedge vga_clk);
        #2;
    endtask

    // gap: percent of idle in_valid cycles; abort_at: beat count at which the
    // abort beat lands (-1 = none); noise: random start pulses during the load.
    task automatic do_load(input bit sel, input int gap, input int abort_at, input bit noise);
        int beats = 0;
        int cyc = 0;
        bit pinned = 0;
        wcnt = 0;
        dcnt = 0;
        start = 1;
        img_sel = sel;
        tick();
        start = 0;
        while (beats < TOTAL && cyc < 20000) begin
            in_valid = (gap == 0) || ($urandom_range(99) >= gap);
            in_data = 8'($urandom);
            abort = (abort_at >= 0) && (beats == abort_at - 1) && in_valid;
            if (noise) start = (beats < TOTAL - 3) ? 1'($urandom_range(1)) : 1'b0;
            if (sel && beats == IMG_W && !pinned) begin
                pinned = 1;
                chk("x_pos_beat237", int'(x_pos), 0);
                chk("y_pos_beat237", int'(y_pos), 1);
            end
            if (in_valid && in_ready) beats++;
            tick();
            cyc++;
            if (abort) break;
        end
        chk("load_timeout", int'(cyc < 20000), 1);
        in_valid = 0;
        abort = 0;
        start = 0;
        if (abort_at < 0) begin
            chk("in_ready_after_done", int'(in_ready), 0);
            chk("busy_after_done", int'(busy), 0);
        end
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 0;
        tick();

        // Reset in the middle of a load at x=10, y=3 with a beat in flight.
        start = 1;
        img_sel = 0;
        tick();
        start = 0;
        in_valid = 1;
        repeat (3 * IMG_W + 10) tick();
        chk("pre_rst_x", int'(x_pos), 10);
        chk("pre_rst_y", int'(y_pos), 3);
        chk("pre_rst_wr_en", int'(wr_en), 1);
        #1 reset = 1;
        #1;
        chk("rst_now_wr_en", int'(wr_en), 0);
        chk("rst_now_busy", int'(busy), 0);
        chk("rst_now_ready", int'(in_ready), 0);
        chk("rst_now_x", int'(x_pos), 0);
        chk("rst_now_y", int'(y_pos), 0);
        chk("rst_now_addr", int'(wr_addr), 0);
        chk("rst_now_data", int'(wr_data), 0);
        in_valid = 0;
        tick();
        reset = 0;
        tick();

        // Image 0, valid always high.
        do_load(0, 0, -1, 0);
        chk("img0_writes", wcnt, TOTAL);
        chk("img0_first", wlog[0], 0);
        chk("img0_last", wlog[TOTAL-1], 4976);
        chk("img0_done_cnt", dcnt, 1);

        // Image 1 with start pulses sprinkled through the load.
        do_load(1, 0, -1, 1);
        chk("img1_writes", wcnt, TOTAL);
        chk("img1_first", wlog[0], 4977);
        chk("img1_beat237", wlog[IMG_W], 5214);
        chk("img1_last", wlog[TOTAL-1], 9953);
        chk("img1_done_cnt", dcnt, 1);

        // Image 0 with ~30% idle cycles on the stream.
        do_load(0, 30, -1, 0);
        chk("gap_writes", wcnt, TOTAL);
        chk("gap_last", wlog[TOTAL-1], 4976);
        chk("gap_done_cnt", dcnt, 1);

        // Abort on the 100th beat.
        do_load(0, 0, 100, 0);
        chk("abort_writes", wcnt, 100);
        chk("abort_last", wlog[99], 99);
        chk("abort_done_cnt", dcnt, 0);
        chk("abort_busy", int'(busy), 0);

        // Image 1 after an abort starts at its base.
        do_load(1, 0, 5, 0);
        chk("restart_writes", wcnt, 5);
        chk("restart_first", wlog[0], 4977);

        // start held high: a new load begins right after done.
        wcnt = 0;
        dcnt = 0;
        start = 1;
        img_sel = 0;
        in_valid = 1;
        tick();
        repeat (TOTAL) tick();
        in_valid = 0;
        chk("held_done_cnt", dcnt + int'(done), 1);
        chk("held_idle_ready", int'(in_ready), 0);
        tick();
        chk("held_reload_busy", int'(busy), 1);
        start = 0;
        abort = 1;
        tick();
        abort = 0;
        chk("held_abort_busy", int'(busy), 0);
        tick();

        // abort wins over start in IDLE.
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        chk("abort_over_start", int'(busy), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
